// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide unit: R-type funct codes and FSM states.
package muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  function automatic logic is_unit_op(input logic [5:0] f);
    return (f == FN_MULTU) || (f == FN_DIVU) || (f == FN_MFHI) ||
           (f == FN_MFLO)  || (f == FN_MTHI) || (f == FN_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the shift-add multiplier or restoring divider.
// acc/lsr hold {product_hi, multiplier} when multiplying and {remainder, quotient} when dividing.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_mode,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lsr,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] lsr_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] addend;

  always_comb begin
    sum      = '0;
    shifted  = '0;
    addend   = '0;
    acc_next = acc;
    lsr_next = lsr;
    if (div_mode) begin
      // Remainder stays below the divisor, so the trial difference always fits WIDTH bits.
      shifted = {acc, lsr[WIDTH-1]};
      if (shifted >= {1'b0, operand}) begin
        sum      = shifted - {1'b0, operand};
        acc_next = sum[WIDTH-1:0];
        lsr_next = {lsr[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = shifted[WIDTH-1:0];
        lsr_next = {lsr[WIDTH-2:0], 1'b0};
      end
    end else begin
      addend   = lsr[0] ? operand : '0;
      sum      = {1'b0, acc} + {1'b0, addend};
      acc_next = sum[WIDTH:1];
      lsr_next = {sum[0], lsr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned MULTU/DIVU unit owning HI/LO; serves MF*/MT* and raises the EX stall.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             kill,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned      CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lsr;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] lsr_next;
  logic             accept;

  assign accept = req_valid & ~kill & (state == ST_IDLE);
  assign stall  = req_valid & is_unit_op(funct) & busy;

  always_comb begin
    rd_data = '0;
    case (funct)
      FN_MFHI: rd_data = hi;
      FN_MFLO: rd_data = lo;
      default: rd_data = '0;
    endcase
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state == ST_DIV),
    .operand  (operand),
    .acc      (acc),
    .lsr      (lsr),
    .acc_next (acc_next),
    .lsr_next (lsr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      operand <= '0;
      acc     <= '0;
      lsr     <= '0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (funct)
              FN_MULTU: begin
                state   <= ST_MUL;
                busy    <= 1'b1;
                cnt     <= '0;
                operand <= src_a;
                acc     <= '0;
                lsr     <= src_b;
              end
              FN_DIVU: begin
                state   <= ST_DIV;
                busy    <= 1'b1;
                cnt     <= '0;
                operand <= src_b;
                acc     <= '0;
                lsr     <= src_a;
              end
              FN_MTHI: hi <= src_a;
              FN_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        ST_MUL, ST_DIV: begin
          // A kill landing on the final iteration still wins: nothing is committed.
          if (kill) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_next;
            lsr <= lsr_next;
            cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
            if (cnt == LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              hi    <= acc_next;
              lo    <= lsr_next;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table with scoreboard plus stall/kill/reset sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [5:0]   funct;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         kill;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] rd_data;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .funct     (funct),
    .src_a     (src_a),
    .src_b     (src_b),
    .kill      (kill),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .rd_data   (rd_data),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] expv;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t vecs[8];
  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    if (fn == FN_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
      return p;
    end
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    return {a % b, a / b};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   done_at;
    int   done_cnt;
    int   busy_cnt;
    res_t e;
    sync();
    req_valid = 1'b1;
    funct     = v.fn;
    src_a     = v.a;
    src_b     = v.b;
    sb.push_back('{v.expv[63:32], v.expv[31:0]});
    sync();
    req_valid = 1'b0;
    funct     = 6'h00;
    done_at   = -1;
    done_cnt  = 0;
    busy_cnt  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = i;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("vec%0d_hi", idx), 64'(hi), 64'(e.hi));
            check($sformatf("vec%0d_lo", idx), 64'(lo), 64'(e.lo));
          end
        end
      end
    end
    if (done_at < 0) begin
      check($sformatf("vec%0d_done_timeout", idx), 64'(0), 64'(1));
      if (sb.size() > 0) void'(sb.pop_front());
    end
    check($sformatf("vec%0d_busy_cycles", idx), 64'(busy_cnt), 64'(32));
    check($sformatf("vec%0d_done_at", idx), 64'(done_at), 64'(32));
    check($sformatf("vec%0d_done_pulses", idx), 64'(done_cnt), 64'(1));
  endtask

  initial begin
    int   stall_cnt;
    int   overlap;
    int   done_cnt;
    bit   got;
    res_t e;

    vecs[0] = '{FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0};
    vecs[1] = '{FN_DIVU,  32'd100,       32'd7,         64'h0};
    vecs[2] = '{FN_DIVU,  32'h8000_0000, 32'd3,         64'h0};
    vecs[3] = '{FN_DIVU,  32'd5,         32'd0,         64'h0};
    vecs[4] = '{FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 64'h0};
    vecs[5] = '{FN_DIVU,  32'd3,         32'd10,        64'h0};
    vecs[6] = '{FN_DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0};
    vecs[7] = '{FN_MULTU, 32'h8000_0001, 32'd0,         64'h0};
    for (int i = 0; i < 8; i++) vecs[i].expv = model(vecs[i].fn, vecs[i].a, vecs[i].b);

    rst       = 1'b1;
    req_valid = 1'b0;
    funct     = 6'h00;
    src_a     = '0;
    src_b     = '0;
    kill      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_hi", 64'(hi), 64'(0));
    check("reset_lo", 64'(lo), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));

    // Table-driven MULTU/DIVU vectors.
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);
    check("plan_mul_hi", 64'(vecs[0].expv[63:32]), 64'(32'hFFFF_FFFE));

    // MULTU 6x7 followed by MFLO held in EX while busy.
    sync();
    req_valid = 1'b1;
    funct     = FN_MULTU;
    src_a     = 32'd6;
    src_b     = 32'd7;
    sb.push_back('{32'd0, 32'd42});
    sync();
    funct     = FN_MFLO;
    src_a     = '0;
    src_b     = '0;
    stall_cnt = 0;
    overlap   = 0;
    got       = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (stall && done) overlap++;
      if (stall) stall_cnt++;
      else begin
        got = 1'b1;
        check("mflo_rd_data", 64'(rd_data), 64'(42));
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("mul67_hi", 64'(hi), 64'(e.hi));
          check("mul67_lo", 64'(lo), 64'(e.lo));
        end
      end
    end
    if (!got) check("stall_timeout", 64'(0), 64'(1));
    check("stall_cycles", 64'(stall_cnt), 64'(32));
    check("stall_done_overlap", 64'(overlap), 64'(0));
    sync();
    req_valid = 1'b0;
    funct     = 6'h00;

    // Preload HI/LO, then kill a MULTU at iteration 10.
    sync();
    req_valid = 1'b1;
    funct     = FN_MTHI;
    src_a     = 32'h1111_1111;
    sync();
    funct = FN_MTLO;
    sync();
    req_valid = 1'b0;
    @(negedge clk);
    check("mthi_hi", 64'(hi), 64'(32'h1111_1111));
    check("mtlo_lo", 64'(lo), 64'(32'h1111_1111));
    sync();
    req_valid = 1'b1;
    funct     = FN_MULTU;
    src_a     = 32'd3;
    src_b     = 32'd5;
    sync();
    funct = 6'h20;
    @(negedge clk);
    check("kill_run_busy", 64'(busy), 64'(1));
    check("nonunit_no_stall", 64'(stall), 64'(0));
    req_valid = 1'b0;
    repeat (9) sync();
    kill = 1'b1;
    sync();
    kill = 1'b0;
    @(negedge clk);
    check("kill_busy", 64'(busy), 64'(0));
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("kill_no_done", 64'(done_cnt), 64'(0));
    check("kill_hi", 64'(hi), 64'(32'h1111_1111));
    check("kill_lo", 64'(lo), 64'(32'h1111_1111));

    // Kill in IDLE beats a start and an MT* write.
    sync();
    req_valid = 1'b1;
    funct     = FN_MULTU;
    src_a     = 32'd2;
    src_b     = 32'd2;
    kill      = 1'b1;
    sync();
    funct = FN_MTHI;
    src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    check("idle_kill_no_start", 64'(busy), 64'(0));
    sync();
    kill      = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("idle_kill_no_mthi", 64'(hi), 64'(32'h1111_1111));

    // Reset mid-DIVU, then MTHI/MFHI.
    sync();
    req_valid = 1'b1;
    funct     = FN_DIVU;
    src_a     = 32'd100;
    src_b     = 32'd7;
    sync();
    req_valid = 1'b0;
    repeat (4) sync();
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_hi", 64'(hi), 64'(0));
    check("rst_mid_lo", 64'(lo), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    sync();
    req_valid = 1'b1;
    funct     = FN_MTHI;
    src_a     = 32'h1234_5678;
    sync();
    funct = FN_MFHI;
    src_a = '0;
    @(negedge clk);
    check("mthi2_hi", 64'(hi), 64'(32'h1234_5678));
    check("mfhi_rd_data", 64'(rd_data), 64'(32'h1234_5678));
    check("mfhi_no_stall", 64'(stall), 64'(0));
    sync();
    req_valid = 1'b0;
    funct     = 6'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle unsigned multiply/divide unit with HI/LO registers, sitting beside the single-cycle ALU/shifter in EX.
- Sequences a 32-iteration shift-add multiplier and a restoring divider.
- Owns HI/LO, serves MFHI/MFLO/MTHI/MTLO, and generates the EX stall that holds the pipeline while an operation runs.
- Decodes the same 6-bit R-type funct field the ALU uses.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  EX holds an R-type instruction for this unit
- funct  in  6  MULTU=6'h19, DIVU=6'h1B, MFHI=6'h10, MFLO=6'h12, MTHI=6'h11, MTLO=6'h13; other codes ignored
- src_a  in  WIDTH  rs value (multiplicand/dividend; MTHI/MTLO data)
- src_b  in  WIDTH  rt value (multiplier/divisor)
- kill  in  1  pipeline flush of the instruction in flight
- stall  out  1  hold EX/earlier stages this cycle
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, HI/LO just committed by MULTU/DIVU
- rd_data  out  WIDTH  MFHI→hi, MFLO→lo, else 0 (combinational)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state IDLE, counter 0, hi=lo=0, busy=0, done=0, stall=0. Reset mid-run aborts the operation with no commit.
- States: IDLE, MUL, DIV.
  - IDLE→MUL on req_valid & funct==MULTU & !kill.
  - IDLE→DIV on req_valid & funct==DIVU & !kill.
  - MUL/DIV→IDLE when the counter reaches WIDTH-1, or on kill.
- Acceptance:
  - Start is accepted at edge E0. Operands are latched and the counter is cleared.
  - busy=1 from after E0 through the cycle before E32. The iteration step runs on E1..E32.
  - HI/LO commit on E32 and busy falls.
  - done=1 for exactly the cycle after E32.
- MULTU: {hi,lo} = src_a*src_b, full 64-bit unsigned product.
- DIVU: lo = src_a/src_b, hi = src_a%src_b (unsigned, restoring).
- Divide by zero: no special path; the result falls out as lo=all-ones and hi=src_a, with the same 32-cycle latency.
- MTHI/MTLO in IDLE: write src_a to hi/lo on the next edge (1 cycle), no stall.
- MFHI/MFLO in IDLE: rd_data reflects the current hi/lo the same cycle, no stall.
- stall = req_valid & (funct ∈ {MULTU,DIVU,MFHI,MFLO,MTHI,MTLO}) & busy.
  - The pipeline holds the request unchanged while stalled.
  - The request is serviced in the first cycle busy=0, reading committed values.
- A request held by stall in the commit cycle sees the new hi/lo; it is not started twice.
- Non-unit funct never stalls and never changes state.
- kill:
  - In MUL/DIV: return to IDLE next edge, hi/lo unchanged, no done.
  - In IDLE: kill beats a simultaneous start or MT* write (nothing happens).
- Counter is log2(WIDTH)+1 bits and saturates; no wrap is observable because the state exits at WIDTH-1.
- Internal working registers are not visible; hi/lo outputs change only on commit, MT*, or reset.

Decomposition:
- Package muldiv_pkg: funct constants (FN_MULTU, FN_DIVU, FN_MFHI, FN_MFLO, FN_MTHI, FN_MTLO) and the state enum (ST_IDLE, ST_MUL, ST_DIV).
- Sub-module muldiv_step: combinational single iteration.
  - Multiply: conditional add + right shift of {acc,mplr}.
  - Divide: left shift, trial subtract, quotient bit.
- Top level holds the FSM, counter, operand/working registers, HI/LO, and the stall/rd_data logic.

Test Plan:
- MULTU 0xFFFFFFFF×0xFFFFFFFF → busy high 32 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- DIVU 100/7 → lo=14, hi=2 after E32. DIVU 0x80000000/3 → lo=0x2AAAAAAA, hi=2.
- DIVU 5/0 → lo=0xFFFFFFFF, hi=5, latency 32, no hang.
- MULTU 6×7, then MFLO held in EX next cycle → stall=1 for remaining busy cycles; first unstalled cycle rd_data=42; stall and done never both 1.
- MULTU started with hi=lo=0x11111111, kill at iteration 10 → busy=0 next cycle; hi/lo still 0x11111111; done never pulses. kill with MULTU in IDLE → nothing starts.
- rst asserted mid-DIVU → next cycle busy=0, hi=lo=0. Then MTHI 0x12345678 → hi=0x12345678 next cycle; MFHI same cycle after returns it.
